// File: rtl/lcd_arb_pkg.sv
// Shared types and sizes for the LCD source arbiter slice.
package lcd_arb_pkg;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHOW    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    function automatic logic [NREQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        return {{(NREQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: search starts one past last_id and wraps.
module rr_pick
    import lcd_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_mask_i,
    input  logic [ID_W-1:0] last_id_i,
    output logic [ID_W-1:0] win_id_o,
    output logic            any_valid_o
);

    logic [ID_W-1:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest set bit is the last writer.
    always_comb begin
        win_id_o    = last_id_i;
        any_valid_o = 1'b0;
        cand_s      = {ID_W{1'b0}};
        for (int off = NREQ; off >= 1; off--) begin
            cand_s      = last_id_i + ID_W'(off);
            win_id_o    = req_mask_i[cand_s] ? cand_s : win_id_o;
            any_valid_o = any_valid_o | req_mask_i[cand_s];
        end
    end

endmodule

// File: rtl/lcd_src_arbiter.sv
// Arbitrates four hex-word sources onto one LCD num bus with dwell-based rotation
// and a manual pin override.
module lcd_src_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int DWELL = 50000000,
    parameter int NREQ  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] src_data,
    input  logic                   pin_en,
    input  logic [ID_W-1:0]        pin_sel,
    output logic [NREQ-1:0]        grant,
    output logic [DATA_W-1:0]      num,
    output logic                   active,
    output logic [ID_W-1:0]        active_id
);

    localparam int               CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    arb_state_e         state_q;
    logic [ID_W-1:0]    cur_id_q;
    logic [ID_W-1:0]    last_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NREQ-1:0]    grant_q;
    logic [DATA_W-1:0]  num_q;
    logic               active_q;
    logic [ID_W-1:0]    active_id_q;

    logic [DATA_W-1:0]  src_arr_s [NREQ];
    logic [ID_W-1:0]    win_id_s;
    logic               any_valid_s;
    logic               other_req_s;
    logic               show_exit_s;

    for (genvar i = 0; i < NREQ; i++) begin : g_src
        assign src_arr_s[i] = src_data[i*DATA_W +: DATA_W];
    end

    rr_pick u_rr_pick (
        .req_mask_i  (req),
        .last_id_i   (last_id_q),
        .win_id_o    (win_id_s),
        .any_valid_o (any_valid_s)
    );

    // Decide whether the current owner gives up the display this cycle.
    always_comb begin
        other_req_s = |(req & ~id_onehot(cur_id_q));
        show_exit_s = 1'b0;
        if (pin_en) begin
            show_exit_s = (pin_sel != cur_id_q);
        end else if (!req[cur_id_q]) begin
            show_exit_s = 1'b1;
        end else if ((cnt_q == CNT_MAX) && other_req_s) begin
            show_exit_s = 1'b1;
        end else begin
            show_exit_s = 1'b0;
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_id_q    <= {ID_W{1'b0}};
            last_id_q   <= ID_W'(NREQ - 1);
            cnt_q       <= {CNT_W{1'b0}};
            grant_q     <= {NREQ{1'b0}};
            num_q       <= {DATA_W{1'b0}};
            active_q    <= 1'b0;
            active_id_q <= {ID_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    grant_q  <= {NREQ{1'b0}};
                    active_q <= 1'b0;
                    cnt_q    <= {CNT_W{1'b0}};
                    if (pin_en) begin
                        cur_id_q <= pin_sel;
                        state_q  <= ST_LOAD;
                    end else if (any_valid_s) begin
                        cur_id_q <= win_id_s;
                        state_q  <= ST_LOAD;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    num_q       <= src_arr_s[cur_id_q];
                    grant_q     <= id_onehot(cur_id_q);
                    active_q    <= 1'b1;
                    active_id_q <= cur_id_q;
                    cnt_q       <= {CNT_W{1'b0}};
                    state_q     <= ST_SHOW;
                end
                ST_SHOW: begin
                    // Live tracking: the owner's word is re-sampled every cycle.
                    num_q <= src_arr_s[cur_id_q];
                    if (show_exit_s) begin
                        grant_q  <= {NREQ{1'b0}};
                        active_q <= 1'b0;
                        state_q  <= ST_RELEASE;
                    end else begin
                        cnt_q    <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        state_q  <= ST_SHOW;
                    end
                end
                ST_RELEASE: begin
                    last_id_q <= cur_id_q;
                    grant_q   <= {NREQ{1'b0}};
                    active_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    grant_q  <= {NREQ{1'b0}};
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign num       = num_q;
    assign active    = active_q;
    assign active_id = active_id_q;

endmodule

// File: tb/tb_lcd_src_arbiter.sv
// Self-checking bench: behavioural ownership model plus directed literal scenarios.
module tb_lcd_src_arbiter;

    localparam int DW = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [127:0] src_w [4];
    logic [511:0] src_data;
    logic         pin_en = 1'b0;
    logic [1:0]   pin_sel = 2'd0;
    logic [3:0]   grant;
    logic [127:0] num;
    logic         active;
    logic [1:0]   active_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign src_data = {src_w[3], src_w[2], src_w[1], src_w[0]};

    lcd_src_arbiter #(.DWELL(DW), .NREQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .src_data  (src_data),
        .pin_en    (pin_en),
        .pin_sel   (pin_sel),
        .grant     (grant),
        .num       (num),
        .active    (active),
        .active_id (active_id)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ownership phases: free, picked (one cycle), owned, dropped (one cycle).
    localparam int P_FREE = 0, P_PICKED = 1, P_OWNED = 2, P_DROPPED = 3;
    int           m_phase, m_cand, m_owner, m_last, m_held;
    logic [3:0]   e_grant;
    logic [127:0] e_num;
    logic         e_active;
    logic [1:0]   e_id;

    function automatic int rr_winner(input logic [3:0] r, input int last);
        for (int off = 1; off <= 4; off++) begin
            if (r[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    function automatic bit owner_leaves(input int owner, input int held);
        logic [3:0] others;
        others = req & ~(4'b0001 << owner);
        if (pin_en) return int'(pin_sel) != owner;
        if (!req[owner]) return 1'b1;
        return (held >= DW - 1) && (others != 4'b0000);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  <= P_FREE;
            m_cand   <= 0;
            m_owner  <= 0;
            m_last   <= 3;
            m_held   <= 0;
            e_grant  <= 4'b0000;
            e_num    <= 128'd0;
            e_active <= 1'b0;
            e_id     <= 2'd0;
        end else begin
            case (m_phase)
                P_FREE: begin
                    if (pin_en) begin
                        m_cand  <= int'(pin_sel);
                        m_phase <= P_PICKED;
                    end else if (rr_winner(req, m_last) >= 0) begin
                        m_cand  <= rr_winner(req, m_last);
                        m_phase <= P_PICKED;
                    end
                end
                P_PICKED: begin
                    m_owner  <= m_cand;
                    e_grant  <= 4'b0001 << m_cand;
                    e_num    <= src_w[m_cand];
                    e_active <= 1'b1;
                    e_id     <= 2'(m_cand);
                    m_held   <= 0;
                    m_phase  <= P_OWNED;
                end
                P_OWNED: begin
                    e_num <= src_w[m_owner];
                    if (owner_leaves(m_owner, m_held)) begin
                        e_grant  <= 4'b0000;
                        e_active <= 1'b0;
                        m_phase  <= P_DROPPED;
                    end else begin
                        m_held <= m_held + 1;
                    end
                end
                default: begin
                    m_last  <= m_owner;
                    m_phase <= P_FREE;
                end
            endcase
        end
    end

    // ---------------- per-cycle comparison ----------------
    int         zrun = 0;
    bit         had_owner = 1'b0;
    logic [3:0] prev_g = 4'b0000;

    always @(negedge clk) begin
        if (reset) begin
            zrun      <= 0;
            had_owner <= 1'b0;
            prev_g    <= 4'b0000;
        end else begin
            check("grant", grant, e_grant);
            check("num", num, e_num);
            check("active", active, e_active);
            check("active_id", active_id, e_id);
            check("grant_onehot", $countones(grant) <= 1, 1'b1);
            if (active) check("grant_vs_id", grant, 4'b0001 << active_id);
            if (grant != 4'b0000 && prev_g != 4'b0000) check("owner_stable", grant, prev_g);
            if (grant != 4'b0000 && prev_g == 4'b0000 && had_owner) check("handover_gap", zrun >= 2, 1'b1);
            if (grant != 4'b0000) begin
                zrun      <= 0;
                had_owner <= 1'b1;
            end else begin
                zrun <= zrun + 1;
            end
            prev_g <= grant;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req     = 4'b0000;
        pin_en  = 1'b0;
        reset   = 1'b1;
        cyc(2);
        reset   = 1'b0;
    endtask

    task automatic wait_grant(input logic [3:0] g, input string nm);
        int n;
        n = 0;
        while (grant !== g && n < 20) begin
            cyc(1);
            n++;
        end
        check(nm, grant, g);
    endtask

    logic [3:0] gq [$];
    int owners [$];
    int runs [$];
    int gaps [$];

    initial begin
        logic [127:0] lit0;
        logic [127:0] all_f;
        logic [3:0]   prev;
        int           run, zr;
        bit           seen;
        lit0  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        all_f = {128{1'b1}};
        for (int i = 0; i < 4; i++) src_w[i] = {$urandom, $urandom, $urandom, $urandom};
        cyc(1);
        check("reset_grant", grant, 4'b0000);
        check("reset_num", num, 128'd0);
        check("reset_active", active, 1'b0);
        check("reset_id", active_id, 2'd0);

        // Single requester: two-cycle latency and held grant.
        do_reset();
        src_w[0] = lit0;
        req = 4'b0001;
        cyc(1);
        check("t1_load", grant, 4'b0000);
        cyc(1);
        check("t1_grant", grant, 4'b0001);
        check("t1_num", num, lit0);
        cyc(20);
        check("t1_hold", grant, 4'b0001);
        req = 4'b0000;
        cyc(1);
        check("t1_release", grant, 4'b0000);
        cyc(4);

        // Two requesters alternate after the dwell.
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            gq.push_back(grant);
        end
        prev = 4'b0000; run = 0; zr = 0; seen = 1'b0;
        foreach (gq[i]) begin
            if (gq[i] != 4'b0000) begin
                if (gq[i] == prev) begin
                    run++;
                end else begin
                    if (prev != 4'b0000) runs.push_back(run);
                    if (seen && prev == 4'b0000) gaps.push_back(zr);
                    owners.push_back(int'(gq[i]));
                    run  = 1;
                    seen = 1'b1;
                end
                zr = 0;
            end else begin
                if (prev != 4'b0000) runs.push_back(run);
                zr++;
            end
            prev = gq[i];
        end
        check("t2_owner_count", owners.size() >= 3, 1'b1);
        if (owners.size() >= 3) begin
            check("t2_owner0", owners[0], 1);
            check("t2_owner1", owners[1], 4);
            check("t2_owner2", owners[2], 1);
        end
        check("t2_run_count", runs.size() >= 2 && gaps.size() >= 2, 1'b1);
        if (runs.size() >= 2 && gaps.size() >= 2) begin
            check("t2_run0", runs[0] >= DW, 1'b1);
            check("t2_run1", runs[1] >= DW, 1'b1);
            check("t2_gap0", gaps[0] >= 2, 1'b1);
            check("t2_gap1", gaps[1] >= 2, 1'b1);
        end
        req = 4'b0000;
        cyc(4);

        // Owner drops its request mid-dwell; pending source takes over.
        do_reset();
        req = 4'b0100;
        wait_grant(4'b0100, "t3_grant2");
        req = 4'b1100;
        cyc(3);
        check("t3_still", grant, 4'b0100);
        req = 4'b1000;
        cyc(1);
        check("t3_release", grant, 4'b0000);
        cyc(2);
        check("t3_gap", grant, 4'b0000);
        cyc(1);
        check("t3_grant3", grant, 4'b1000);
        req = 4'b0000;
        cyc(4);

        // Pin override preempts and persists without any request.
        do_reset();
        req = 4'b0010;
        wait_grant(4'b0010, "t4_grant1");
        pin_en = 1'b1; pin_sel = 2'd3; req = 4'b0000;
        cyc(1);
        check("t4_release", grant, 4'b0000);
        cyc(3);
        check("t4_preempt", grant, 4'b1000);
        cyc(20);
        check("t4_persist", grant, 4'b1000);
        pin_en = 1'b0;
        cyc(1);
        check("t4_drop", grant, 4'b0000);
        cyc(4);

        // Live tracking of the owner's word, then hold after release.
        do_reset();
        src_w[0] = lit0;
        req = 4'b0001;
        wait_grant(4'b0001, "t5_grant0");
        check("t5_num_a", num, lit0);
        src_w[0] = all_f;
        cyc(1);
        check("t5_num_f", num, all_f);
        req = 4'b0000;
        cyc(1);
        check("t5_release", grant, 4'b0000);
        src_w[0] = 128'd0;
        cyc(5);
        check("t5_hold", num, all_f);
        check("t5_inactive", active, 1'b0);

        // Asynchronous reset mid-show; first winner afterwards is source 0.
        do_reset();
        req = 4'b0100;
        wait_grant(4'b0100, "t6_grant2");
        cyc(3);
        reset = 1'b1;
        #1;
        check("t6_rst_grant", grant, 4'b0000);
        check("t6_rst_num", num, 128'd0);
        check("t6_rst_active", active, 1'b0);
        req = 4'b1111;
        cyc(2);
        reset = 1'b0;
        begin
            int n;
            n = 0;
            while (grant == 4'b0000 && n < 20) begin
                cyc(1);
                n++;
            end
        end
        check("t6_first", grant, 4'b0001);
        req = 4'b0000;
        cyc(4);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)   req = 4'($urandom_range(15));
            if ($urandom_range(29) == 0)  pin_en = ~pin_en;
            if ($urandom_range(9) == 0)   pin_sel = 2'($urandom_range(3));
            if ($urandom_range(3) == 0)   src_w[$urandom_range(3)] = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(799) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc(1);
        end
        pin_en = 1'b0;
        req    = 4'b0000;
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
